// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: bus between the convolution sequencer and its environment.
//   Memory side : sram read address / data, wmem read address, sram write
//                 enable / address.
//   Datapath    : wt_load, row_load, row_sel, dim strobes.
//   Control     : dut_run (start request), dut_busy (run in progress).
// The master modport is the sequencer; the slave modport is the memory and
// datapath side.
interface conv_sequencer_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  localparam int NW = $clog2(DW) + 1;

  logic          dut_run;
  logic [DW-1:0] sram_dut_read_data;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [AW-1:0] dut_wmem_read_address;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_sram_write_address;
  logic          wt_load;
  logic          row_load;
  logic [1:0]    row_sel;
  logic [NW-1:0] dim;

  modport master (
    input  dut_run, sram_dut_read_data,
    output dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address,
           wt_load, row_load, row_sel, dim
  );

  modport slave (
    output dut_run, sram_dut_read_data,
    input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address,
           wt_load, row_load, row_sel, dim
  );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: control sequencer for the binary-convolution engine.
// Walks packed matrices in SRAM (word base = N, then N row words), issues
// every SRAM / weight-memory read, strobes the datapath to latch the kernel
// and three input rows, and pulses one output write per convolved row.
// Ports:
//   clk      - clock, rising edge
//   reset_b  - asynchronous reset, active HIGH (name kept from the codebase)
//   bus      - conv_sequencer_if.master (run/busy, memory and datapath strobes)
// All outputs are decoded from the state register and internal registers;
// the read data only steers next state and register updates.
module conv_sequencer #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset_b,
  conv_sequencer_if.master  bus
);
  localparam int RW = $clog2(DW);   // row counter width
  localparam int NW = RW + 1;       // dimension width (holds DW itself)

  typedef enum logic [2:0] {
    IDLE, FETCH_DIM, CAP_DIM, RD0, RD1, RD2, CAP2, WR
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] base, wptr;
  logic [RW-1:0] r;
  logic [NW-1:0] dim_q;

  logic          dim_ok, last_row;
  logic          busy, wt, rl, we;
  logic [1:0]    sel;
  logic [AW-1:0] ra;

  // Valid matrix sizes are 3..DW; anything else (0xFFFF included) ends the run.
  assign dim_ok   = (bus.sram_dut_read_data >= DW'(3)) &&
                    (bus.sram_dut_read_data <= DW'(DW));
  // Row r is the last output row of this matrix when r+1 == N-2.
  assign last_row = (NW'(r) + NW'(1)) == (dim_q - NW'(2));

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state <= IDLE;
      base  <= '0;
      wptr  <= '0;
      r     <= '0;
      dim_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.dut_run) begin
          base <= '0;
          wptr <= '0;
          r    <= '0;
        end
        CAP_DIM: if (dim_ok) begin
          dim_q <= bus.sram_dut_read_data[NW-1:0];
          r     <= '0;
        end
        WR: begin
          wptr <= wptr + 1'b1;            // wraps silently at 2^AW
          r    <= r + 1'b1;
          if (last_row) base <= base + AW'(dim_q) + AW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    wt       = 1'b0;
    rl       = 1'b0;
    we       = 1'b0;
    sel      = 2'd0;
    ra       = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.dut_run) state_nx = FETCH_DIM;
      end
      FETCH_DIM: begin
        ra       = base;
        state_nx = CAP_DIM;
      end
      CAP_DIM: begin
        // kernel word from wmem address 0 is valid now
        wt       = 1'b1;
        state_nx = dim_ok ? RD0 : IDLE;
      end
      RD0: begin
        ra       = base + AW'(r) + AW'(1);
        state_nx = RD1;
      end
      RD1: begin
        // each row_load captures the address presented one cycle earlier
        ra       = base + AW'(r) + AW'(2);
        rl       = 1'b1;
        sel      = 2'd0;
        state_nx = RD2;
      end
      RD2: begin
        ra       = base + AW'(r) + AW'(3);
        rl       = 1'b1;
        sel      = 2'd1;
        state_nx = CAP2;
      end
      CAP2: begin
        rl       = 1'b1;
        sel      = 2'd2;
        state_nx = WR;
      end
      WR: begin
        we       = 1'b1;
        state_nx = last_row ? FETCH_DIM : RD0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.dut_busy               = busy;
  assign bus.dut_sram_read_address  = ra;
  assign bus.dut_wmem_read_address  = '0;
  assign bus.dut_sram_write_enable  = we;
  assign bus.dut_sram_write_address = wptr;
  assign bus.wt_load                = wt;
  assign bus.row_load               = rl;
  assign bus.row_sel                = sel;
  assign bus.dim                    = dim_q;
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer for the binary-convolution engine. It walks the input SRAM matrix by matrix, issues every SRAM and weight-memory read, and tells the convolution datapath when to latch the kernel and each input row. It also issues one output write per convolved row. The sequencer produces no data: the datapath computes `dut_sram_write_data` from the rows it latched under this block's strobes.

## Interface
Parameters:
- `AW`, 12: address width for SRAM and weight memory.
- `DW`, 16: data word width. This is also the maximum matrix dimension.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset_b`  in  1: asynchronous, active-high reset (asserted = 1). The name follows the codebase; the polarity is active-high.
- `dut_run`  in  1: start request, sampled while idle.
- `sram_dut_read_data`  in  16: synchronous SRAM read data, valid one cycle after its address.
- `dut_busy`  out  1: high while a run is in progress.
- `dut_sram_read_address`  out  12: SRAM read address.
- `dut_wmem_read_address`  out  12: weight-memory read address, always 0.
- `dut_sram_write_enable`  out  1: one-cycle pulse per output row.
- `dut_sram_write_address`  out  12: output write pointer.
- `wt_load`  out  1: datapath latches `wmem_dut_read_data[8:0]` as the 3x3 kernel.
- `row_load`  out  1: datapath latches `sram_dut_read_data` into the row register selected by `row_sel`.
- `row_sel`  out  2: row register index, 0..2.
- `dim`  out  5: dimension N of the current matrix, used by the datapath for masking.

## Operation
Memory layout:
- Matrices are packed back to back, starting at SRAM address 0.
- Word `base` holds N. Words `base+1`..`base+N` hold rows 0..N-1, one row per word in bits [N-1:0].
- Any N outside 3..16 (including 0xFFFF) ends the run.
- Each matrix produces N-2 output words. These are written at consecutive addresses starting at 0 and continue across matrices.

Internal registers:
- `base` (12 bits) and `wptr` (12 bits), plus the row counter `r` (4 bits) and `dim` (5 bits).
- All address arithmetic is modulo 2^12.

State machine:
- IDLE: `busy`=0.
  - `dut_run`=1 at an edge moves to FETCH_DIM and clears `base`, `wptr` and `r`.
- FETCH_DIM: read address = `base`, wmem address = 0. Next state is CAP_DIM.
- CAP_DIM: `wt_load`=1.
  - If the read data is in 3..16: latch `dim`, clear `r`, go to RD0.
  - Otherwise: go to IDLE.
- RD0: read address = `base+1+r`. Next state is RD1.
- RD1: read address = `base+2+r`; `row_load`=1 with `row_sel`=0. Next state is RD2.
- RD2: read address = `base+3+r`; `row_load`=1 with `row_sel`=1. Next state is CAP2.
- CAP2: `row_load`=1 with `row_sel`=2. Next state is WR.
- WR: `dut_sram_write_enable`=1 at `wptr`. Then `wptr`++ and `r`++.
  - If `r+1 == dim-2`: `base` += `dim`+1, go to FETCH_DIM.
  - Otherwise: go to RD0.

Rules:
- `dut_run` is ignored in every state except IDLE.
- Outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- The write pointer wraps from 4095 to 0 silently.

## Timing
Reset values (`reset_b`=1): state IDLE, and every output 0 — `dut_busy`, all three addresses, `dut_sram_write_enable`, `wt_load`, `row_load`, `row_sel`, `dim`. Internal `base`, `wptr` and `r` are also 0.

Reset mid-run:
- Asserting `reset_b` aborts the run immediately.
- No write pulse may appear in the cycle after assertion.

Busy and cycle counts:
- `dut_run` sampled at edge k puts the block in FETCH_DIM during cycle k+1, with `dut_busy`=1 from cycle k+1.
- Each output row costs 5 cycles (RD0..WR). Each matrix adds 2 cycles (FETCH_DIM, CAP_DIM).
- The terminating CAP_DIM is the last busy cycle. `dut_busy`=0 in the following cycle.
- Run time is 2 + Σ(2 + 5·(N−2)) cycles.

Read/capture alignment:
- `row_load` for a row always occurs exactly one cycle after that row's address is presented.
- `wt_load` occurs one cycle after wmem address 0 is presented.

## Test plan
1. **Single 3x3 matrix.** SRAM[0]=3, rows at 1..3, SRAM[4]=0xFFFF; pulse `dut_run`.
   - Read addresses in sequence: 0, 1, 2, 3, 4.
   - Exactly one write, address 0, in cycle k+7.
   - `dut_busy` high for cycles k+1..k+9.
2. **Two matrices.** N=4 at base 0, N=16 at base 5, terminator at 22.
   - Writes at addresses 0..1, then 2..15.
   - FETCH_DIM addresses 0, 5, 22.
   - `dim` reads 4, then 16.
3. **Immediate terminator.** SRAM[0]=0xFFFF.
   - `dut_busy` high for 2 cycles, no write pulses, `wt_load` pulses once.
   - SRAM[0]=2 and SRAM[0]=17 behave identically.
4. **Ignored and repeated runs.** Hold `dut_run`=1 throughout scenario 1.
   - No restart and no change to the write sequence while busy.
   - A new `dut_run` after return to idle restarts at SRAM address 0 and write address 0.
5. **Reset mid-run.** Assert `reset_b` during the RD1 state of scenario 2, row 1.
   - All outputs are 0 in the next cycle and stay 0 while reset is held.
   - After release plus `dut_run`, the run repeats from address 0 with identical results.
6. **Address wrap.** Preload `base` near 4094 via a long matrix chain with N=16.
   - Read addresses wrap to 0..2 modulo 4096.
   - The write pointer at 4095 wraps to 0 on the next write.
